// File: rtl/tone_divider_bank.sv
// ---------------------------------------------------------------------------
// tone_divider_bank
//
// Multi-channel tone clock divider. Each channel converts a period word
// (counted in clk_in cycles) into a registered square wave plus a one-cycle
// tick on the last cycle of every period. A new period word is adopted only
// at the end of the current period, or at any time while the channel is
// disabled or silent (active period < 2), so note changes never glitch.
//
// Parameters:
//   WIDTH     period-word width per channel
//   CHANNELS  number of independent channels
//
// Ports:
//   clk_in       system clock
//   reset        synchronous, active-high reset (priority over everything)
//   divisor      per-channel period, channel i at [i*WIDTH +: WIDTH]
//   enable       per-channel run enable
//   duty         (TONE_DUTY_EN only) per-channel 8-bit duty fraction,
//                channel i at [i*8 +: 8]
//   clk_out      per-channel registered tone output
//   period_tick  per-channel pulse on the last cycle of each period
//
// Build option:
//   TONE_DUTY_EN  when defined, the high length is (div_a * duty_a) >> 8
//                 instead of ceil(div_a / 2).
// ---------------------------------------------------------------------------
module tone_divider_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
  input  logic [CHANNELS-1:0]       enable,
`ifdef TONE_DUTY_EN
  input  logic [CHANNELS*8-1:0]     duty,
`endif
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       period_tick
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] high_len;
    logic             clk_r;
    logic             tick_r;
    logic             live;
    logic             last;

`ifdef TONE_DUTY_EN
    logic [7:0]       duty_a;
    logic [WIDTH+7:0] duty_prod;

    // Full-width product so the largest period at full duty cannot overflow.
    assign duty_prod = {8'd0, div_a} * {{WIDTH{1'b0}}, duty_a};
    assign high_len  = duty_prod[WIDTH+7:8];
`else
    // ceil(D/2): the odd cycle goes to the high phase.
    assign high_len = div_a - (div_a >> 1);
`endif

    // Disabled and silent channels behave identically: hold at zero and keep
    // reloading the period so a new note starts on the following edge.
    assign live = enable[ch] && (div_a >= WIDTH'(2));
    assign last = (cnt == div_a - WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt    <= '0;
        div_a  <= '0;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
`ifdef TONE_DUTY_EN
        duty_a <= '0;
`endif
      end else if (!live) begin
        cnt    <= '0;
        div_a  <= divisor[ch*WIDTH +: WIDTH];
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
`ifdef TONE_DUTY_EN
        duty_a <= duty[ch*8 +: 8];
`endif
      end else begin
        clk_r  <= (cnt < high_len);
        tick_r <= last;
        if (last) begin
          // Wrap edge: the only point where a running channel adopts a new
          // period, so the period in progress always completes unchanged.
          cnt   <= '0;
          div_a <= divisor[ch*WIDTH +: WIDTH];
`ifdef TONE_DUTY_EN
          duty_a <= duty[ch*8 +: 8];
`endif
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end

    assign clk_out[ch]     = clk_r;
    assign period_tick[ch] = tick_r;
  end

endmodule

// File: tb/tb_tone_divider_bank.sv
// ---------------------------------------------------------------------------
// tb_tone_divider_bank
//
// Self-checking bench for tone_divider_bank: a table of scripted cycles,
// hand-written sequences for divisor change, silent divisors, enable drop,
// reset restart (and duty, with TONE_DUTY_EN), then a randomized run
// compared against a period-queue reference model.
// ---------------------------------------------------------------------------
module tb_tone_divider_bank;
  localparam int WIDTH    = 32;
  localparam int CHANNELS = 2;

  logic                      clk_in;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] divisor;
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS*8-1:0]     duty;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       period_tick;

  int checks = 0;
  int errors = 0;

  tone_divider_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .divisor     (divisor),
    .enable      (enable),
`ifdef TONE_DUTY_EN
    .duty        (duty),
`endif
    .clk_out     (clk_out),
    .period_tick (period_tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 ns after the edge.
  task automatic step(input logic rst, input logic [1:0] en,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    @(negedge clk_in);
    reset   = rst;
    enable  = en;
    divisor = {d1, d0};
    @(posedge clk_in);
    #1;
  endtask

  // ------------------------------------------------------------------------
  // Reference model: each channel holds a queue of the {clk,tick} values of
  // the period in progress. A whole period is generated from the latched D
  // when the queue runs dry; the new period word is latched when the last
  // entry of a period is played out, or whenever the channel is idle.
  // ------------------------------------------------------------------------
  bit [1:0]         mq    [CHANNELS][$];
  logic [WIDTH-1:0] md    [CHANNELS];
  logic [7:0]       mduty [CHANNELS];
  logic [1:0]       exp_clk;
  logic [1:0]       exp_tick;

  function automatic longint high_of(input longint d, input longint du);
`ifdef TONE_DUTY_EN
    return (d * du) / 256;
`else
    return (d + 1) / 2;
`endif
  endfunction

  task automatic model_step();
    for (int c = 0; c < CHANNELS; c++) begin
      bit [1:0] e;
      exp_clk[c]  = 1'b0;
      exp_tick[c] = 1'b0;
      if (reset) begin
        mq[c].delete();
        md[c]    = '0;
        mduty[c] = '0;
      end else if (!enable[c] || (mq[c].size() == 0 && md[c] < 2)) begin
        mq[c].delete();
        md[c]    = divisor[c*WIDTH +: WIDTH];
        mduty[c] = duty[c*8 +: 8];
      end else begin
        if (mq[c].size() == 0) begin
          longint d = longint'(md[c]);
          longint h = high_of(d, longint'(mduty[c]));
          for (longint k = 0; k < d; k++)
            mq[c].push_back({k < h, k == d - 1});
        end
        e = mq[c].pop_front();
        exp_clk[c]  = e[1];
        exp_tick[c] = e[0];
        if (mq[c].size() == 0) begin
          md[c]    = divisor[c*WIDTH +: WIDTH];
          mduty[c] = duty[c*8 +: 8];
        end
      end
    end
  endtask

  typedef struct {
    logic             rst;
    logic [1:0]       en;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [1:0]       exp_clk;
    logic [1:0]       exp_tick;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] en, input int d0, input int d1,
                              input logic [1:0] ec, input logic [1:0] et);
    vec_t v;
    v.rst = rst; v.en = en; v.d0 = WIDTH'(d0); v.d1 = WIDTH'(d1);
    v.exp_clk = ec; v.exp_tick = et;
    return v;
  endfunction

  initial begin
    vec_t vecs[15];
    int   pc[10];
    int   pt[10];
    int   k;

    reset   = 1'b1;
    enable  = '0;
    divisor = '0;
    duty    = {8'd128, 8'd128};   // half duty: same high lengths as ceil(D/2) for even D

    // ch0 D=4 enabled, ch1 disabled, then ch1 D=2 joins.
    vecs[0]  = mk(1, 2'b00, 4, 2, 2'b00, 2'b00);
    vecs[1]  = mk(0, 2'b00, 4, 2, 2'b00, 2'b00);
    vecs[2]  = mk(0, 2'b01, 4, 2, 2'b01, 2'b00);
    vecs[3]  = mk(0, 2'b01, 4, 2, 2'b01, 2'b00);
    vecs[4]  = mk(0, 2'b01, 4, 2, 2'b00, 2'b00);
    vecs[5]  = mk(0, 2'b01, 4, 2, 2'b00, 2'b01);
    vecs[6]  = mk(0, 2'b01, 4, 2, 2'b01, 2'b00);
    vecs[7]  = mk(0, 2'b01, 4, 2, 2'b01, 2'b00);
    vecs[8]  = mk(0, 2'b01, 4, 2, 2'b00, 2'b00);
    vecs[9]  = mk(0, 2'b01, 4, 2, 2'b00, 2'b01);
    vecs[10] = mk(0, 2'b11, 4, 2, 2'b11, 2'b00);
    vecs[11] = mk(0, 2'b11, 4, 2, 2'b01, 2'b10);
    vecs[12] = mk(0, 2'b11, 4, 2, 2'b10, 2'b00);
    vecs[13] = mk(0, 2'b11, 4, 2, 2'b00, 2'b11);
    vecs[14] = mk(0, 2'b00, 4, 2, 2'b00, 2'b00);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].d0, vecs[i].d1);
      check($sformatf("table_clk[%0d]", i), 32'(clk_out), 32'(vecs[i].exp_clk));
      check($sformatf("table_tick[%0d]", i), 32'(period_tick), 32'(vecs[i].exp_tick));
    end

    // Divisor 4 -> 6 on the second cycle of a period.
    pc = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    pt = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    step(0, 2'b00, 4, 2);
    for (int i = 0; i < 10; i++) begin
      step(0, 2'b01, (i >= 1) ? 6 : 4, 2);
      check($sformatf("div_change_clk[%0d]", i), 32'(clk_out[0]), 32'(pc[i]));
      check($sformatf("div_change_tick[%0d]", i), 32'(period_tick[0]), 32'(pt[i]));
    end

    // Silent divisors 0 and 1, then D=4.
    step(0, 2'b00, 0, 2);
    for (int i = 0; i < 6; i++) begin
      step(0, 2'b01, (i < 3) ? 0 : 1, 2);
      check($sformatf("silent_clk[%0d]", i), 32'(clk_out), 32'd0);
      check($sformatf("silent_tick[%0d]", i), 32'(period_tick), 32'd0);
    end
    step(0, 2'b01, 4, 2);   // silent edge adopts D=4
    check("silent_load_clk", 32'(clk_out[0]), 32'd0);
    pc[0:3] = '{1, 1, 0, 0};
    pt[0:3] = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b01, 4, 2);
      check($sformatf("after_silent_clk[%0d]", i), 32'(clk_out[0]), 32'(pc[i]));
      check($sformatf("after_silent_tick[%0d]", i), 32'(period_tick[0]), 32'(pt[i]));
    end

    // Enable dropped mid-high-phase with D=8, then re-enabled.
    step(0, 2'b00, 8, 2);
    step(0, 2'b01, 8, 2);
    step(0, 2'b01, 8, 2);
    check("drop_pre_clk", 32'(clk_out[0]), 32'd1);
    step(0, 2'b00, 8, 2);
    check("drop_clk", 32'(clk_out[0]), 32'd0);
    check("drop_tick", 32'(period_tick[0]), 32'd0);
    step(0, 2'b00, 8, 2);
    for (int i = 0; i < 8; i++) begin
      step(0, 2'b01, 8, 2);
      check($sformatf("reenable_clk[%0d]", i), 32'(clk_out[0]), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("reenable_tick[%0d]", i), 32'(period_tick[0]), (i == 7) ? 32'd1 : 32'd0);
    end

    // Reset pulsed mid-period with D=6; wait (bounded) for the restart.
    step(0, 2'b00, 6, 2);
    for (int i = 0; i < 4; i++) step(0, 2'b01, 6, 2);
    step(1, 2'b01, 6, 2);
    check("reset_clk", 32'(clk_out), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);
    k = 0;
    do begin
      step(0, 2'b01, 6, 2);
      k++;
    end while (clk_out[0] == 1'b0 && k < 4);
    check("reset_restart_seen", 32'(clk_out[0]), 32'd1);
    pc[0:4] = '{1, 1, 0, 0, 0};
    pt[0:4] = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b01, 6, 2);
      check($sformatf("restart_clk[%0d]", i), 32'(clk_out[0]), 32'(pc[i]));
      check($sformatf("restart_tick[%0d]", i), 32'(period_tick[0]), 32'(pt[i]));
    end

`ifdef TONE_DUTY_EN
    // Quarter duty with D=8: 2 high, 6 low.
    duty = {8'd128, 8'd64};
    step(0, 2'b00, 8, 2);
    for (int i = 0; i < 8; i++) begin
      step(0, 2'b01, 8, 2);
      check($sformatf("duty_clk[%0d]", i), 32'(clk_out[0]), (i < 2) ? 32'd1 : 32'd0);
      check($sformatf("duty_tick[%0d]", i), 32'(period_tick[0]), (i == 7) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized run against the reference model, starting from reset.
    begin
      logic [1:0]       en_r;
      logic [WIDTH-1:0] d_r [CHANNELS];
      en_r = 2'b11;
      d_r[0] = 5;
      d_r[1] = 2;
      step(1, en_r, d_r[0], d_r[1]);
      model_step();
      for (int i = 0; i < 3000; i++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if ($urandom_range(0, 7) == 0) d_r[c] = WIDTH'($urandom_range(0, 9));
          if ($urandom_range(0, 39) == 0) en_r[c] = ~en_r[c];
`ifdef TONE_DUTY_EN
          if ($urandom_range(0, 15) == 0) duty[c*8 +: 8] = 8'($urandom);
`endif
        end
        step(($urandom_range(0, 199) == 0), en_r, d_r[0], d_r[1]);
        model_step();
        check($sformatf("rand_clk[%0d]", i), 32'(clk_out), 32'(exp_clk));
        check($sformatf("rand_tick[%0d]", i), 32'(period_tick), 32'(exp_tick));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
